// File: rtl/alk_muldiv_seq_pkg.sv
// ============================================================================
// Module  : alk_pkg
// Brief   : Shared types and helpers for the ALK multiply/divide sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alk_pkg;

  typedef enum logic [2:0] {
    PASS = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    ZERO = 3'd3
  } alk_op_e;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_DIV  = 2'd1,
    MODE_REM  = 2'd2,
    MODE_MULS = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_STEP = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Reserved size code 3 runs as a full-width operation.
  function automatic int unsigned size_steps(input logic [1:0] dsize,
                                             input int unsigned width);
    int unsigned n;
    case (dsize)
      2'd0:    n = 8;
      2'd1:    n = 16;
      default: n = width;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alk_muldiv_seq_if.sv
// ============================================================================
// Module  : alk_muldiv_seq_if
// Brief   : Control bundle between microsequencer/ALP slices and the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alk_muldiv_seq_if;
  import alk_pkg::*;

  logic        start_h;
  logic [1:0]  mode_h;
  logic [1:0]  dsize_h;
  logic        abort_h;
  logic        c32_in_h;
  logic        q_sout_shr_h;
  alk_op_e     alk_op_h;
  logic        cin_h;
  logic        q_sin_h;
  logic        loop_f_h;
  logic        busy_h;
  logic        done_h;

  modport master (
    output start_h, mode_h, dsize_h, abort_h, c32_in_h, q_sout_shr_h,
    input  alk_op_h, cin_h, q_sin_h, loop_f_h, busy_h, done_h
  );

  modport slave (
    input  start_h, mode_h, dsize_h, abort_h, c32_in_h, q_sout_shr_h,
    output alk_op_h, cin_h, q_sin_h, loop_f_h, busy_h, done_h
  );

endinterface

`default_nettype wire

// File: rtl/alk_muldiv_seq_step_ctr.sv
// ============================================================================
// Module  : alk_step_ctr
// Brief   : Loadable step down-counter with last-step and loop indications.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alk_step_ctr #(
  parameter int CNT_W = 6
) (
  input  wire logic             qdclk_l,
  input  wire logic             rst_l,
  input  wire logic             i_clr,
  input  wire logic             i_load,
  input  wire logic             i_dec,
  input  wire logic [CNT_W-1:0] i_load_val,
  output logic                  o_last,
  output logic                  o_loop
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge qdclk_l) begin
    if (!rst_l || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_last = (r_count == CNT_W'(1));
  assign o_loop = (r_count >  CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/alk_muldiv_seq.sv
// ============================================================================
// Module  : alk_muldiv_seq
// Brief   : Step sequencer for shift-add multiply and non-restoring divide.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alk_muldiv_seq
  import alk_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_MUL = 1'b1
) (
  input  wire logic       qdclk_l,
  input  wire logic       rst_l,
  alk_muldiv_seq_if.slave bus
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  mode_e                r_mode;
  logic [1:0]           r_dsize;
  logic                 r_qbit;

  alk_op_e              w_op;
  logic                 w_q_sin;
  logic                 w_loop_f;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_ctr_clr;
  logic                 w_ctr_load;
  logic                 w_ctr_dec;
  logic                 w_last;
  logic                 w_loop;
  logic                 w_muls_en;
  logic                 w_is_mul;
  logic                 w_is_muls;
  logic [c_cnt_w-1:0]   w_steps;

  generate
    if (SIGNED_MUL) begin : g_muls_on
      assign w_muls_en = 1'b1;
    end else begin : g_muls_off
      assign w_muls_en = 1'b0;
    end
  endgenerate

  assign w_steps   = c_cnt_w'(size_steps(r_dsize, WIDTH));
  assign w_is_mul  = (r_mode == MODE_MUL) || (r_mode == MODE_MULS);
  assign w_is_muls = w_muls_en && (r_mode == MODE_MULS);

  alk_step_ctr #(
    .CNT_W (c_cnt_w)
  ) u_step_ctr (
    .qdclk_l    (qdclk_l),
    .rst_l      (rst_l),
    .i_clr      (w_ctr_clr),
    .i_load     (w_ctr_load),
    .i_dec      (w_ctr_dec),
    .i_load_val (w_steps),
    .o_last     (w_last),
    .o_loop     (w_loop)
  );

  // Seeding the quotient bit with 1 at INIT makes the first divide step a SUB.
  always_ff @(posedge qdclk_l) begin
    if (!rst_l) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_MUL;
      r_dsize <= 2'd0;
      r_qbit  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && bus.start_h) begin
        r_mode  <= mode_e'(bus.mode_h);
        r_dsize <= bus.dsize_h;
      end
      if (r_state == S_INIT) begin
        r_qbit <= 1'b1;
      end else if ((r_state == S_STEP) && !w_is_mul) begin
        r_qbit <= bus.c32_in_h;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op        = PASS;
    w_q_sin     = 1'b0;
    w_loop_f    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_ctr_clr   = 1'b0;
    w_ctr_load  = 1'b0;
    w_ctr_dec   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start_h) begin
          w_state_nxt = S_INIT;
        end
      end

      S_INIT: begin
        w_op     = ZERO;
        w_loop_f = 1'b1;
        w_busy   = 1'b1;
        if (bus.abort_h) begin
          w_state_nxt = S_IDLE;
          w_ctr_clr   = 1'b1;
        end else begin
          w_state_nxt = S_STEP;
          w_ctr_load  = 1'b1;
        end
      end

      S_STEP: begin
        w_busy    = 1'b1;
        w_loop_f  = w_loop;
        w_ctr_dec = 1'b1;
        if (w_is_mul) begin
          // Signed multiply: the multiplier MSB carries negative weight.
          if (bus.q_sout_shr_h) begin
            w_op = (w_is_muls && w_last) ? SUB : ADD;
          end
        end else begin
          w_op    = r_qbit ? SUB : ADD;
          w_q_sin = bus.c32_in_h;
        end
        if (bus.abort_h) begin
          w_state_nxt = S_IDLE;
          w_ctr_clr   = 1'b1;
        end else if (w_last) begin
          if ((r_mode == MODE_REM) && !bus.c32_in_h) begin
            w_state_nxt = S_FIX;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_FIX: begin
        w_op   = ADD;
        w_busy = 1'b1;
        if (bus.abort_h) begin
          w_state_nxt = S_IDLE;
          w_ctr_clr   = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.alk_op_h = w_op;
  assign bus.cin_h    = (w_op == SUB);
  assign bus.q_sin_h  = w_q_sin;
  assign bus.loop_f_h = w_loop_f;
  assign bus.busy_h   = w_busy;
  assign bus.done_h   = w_done;

endmodule

`default_nettype wire
